// File: rtl/chip_params.sv
// Chip-level constants shared by the pad ring, plus the per-pin filter decision helper.
package chip_params;

    localparam int unsigned CHIP_PORT_A_WIDTH = 16;
    localparam int unsigned PAD_SYNC_STAGES   = 2;
    localparam int unsigned PAD_FILT_W        = 4;

    // What the glitch filter does with one pin on the coming clock edge.
    typedef enum logic [2:0] {
        FA_HOLD,    // filt_en just toggled: keep output, restart counter
        FA_BYPASS,  // filter off: output follows synchronised input
        FA_MATCH,   // input agrees with output: counter back to zero
        FA_COUNT,   // input differs, not yet stable long enough
        FA_UPDATE   // input differs and has been stable long enough
    } filt_act_e;

    function automatic filt_act_e filt_action(
        input logic en,
        input logic en_q,
        input logic s,
        input logic din,
        input logic at_len
    );
        filt_act_e act;
        if (en != en_q)   act = FA_HOLD;
        else if (!en)     act = FA_BYPASS;
        else if (s == din) act = FA_MATCH;
        else if (at_len)  act = FA_UPDATE;
        else              act = FA_COUNT;
        return act;
    endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pin's input path: synchroniser chain, glitch-filter counter, filtered data and
// its one-cycle-delayed copy used for edge detection in the parent.
module pad_in_filter
    import chip_params::*;
#(
    parameter int unsigned SYNC_STAGES = PAD_SYNC_STAGES,
    parameter int unsigned FILT_W      = PAD_FILT_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              raw,
    input  logic              filt_en,
    input  logic [FILT_W-1:0] filt_len,
    output logic              din,
    output logic              prev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      cnt;
    logic                   en_q;
    filt_act_e              act;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pad value through the metastability chain.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Decide the filter action; >= also catches a count left above a freshly lowered filt_len.
    always_comb begin
        act = filt_action(filt_en, en_q, s, din, cnt >= filt_len);
    end

    // Filter counter and filtered output register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            din <= 1'b0;
        end else begin
            case (act)
                FA_BYPASS: begin
                    din <= s;
                    cnt <= '0;
                end
                FA_UPDATE: begin
                    din <= s;
                    cnt <= '0;
                end
                FA_COUNT:  cnt <= cnt + 1'b1;
                default:   cnt <= '0;
            endcase
        end
    end

    // Remember last filter enable and last filtered value.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            prev <= 1'b0;
        end else begin
            en_q <= filt_en;
            prev <= din;
        end
    end

endmodule

// File: rtl/std_pad.sv
// Bidirectional pad cell: tri-state output driver and ie-gated input buffer.
module std_pad (
    inout  wire  PAD,
    input  logic dout,
    input  logic oe,
    input  logic ie,
    output logic din
);

    assign PAD = oe ? dout : 1'bz;
    assign din = ie & PAD;

endmodule

// File: rtl/pad_port_filt.sv
// GPIO pad port: WIDTH pad cells with synchronised, glitch-filtered inputs and
// sticky per-pin rise/fall interrupt flags.
module pad_port_filt
    import chip_params::*;
#(
    parameter int unsigned WIDTH       = CHIP_PORT_A_WIDTH,
    parameter int unsigned SYNC_STAGES = PAD_SYNC_STAGES,
    parameter int unsigned FILT_W      = PAD_FILT_W
) (
    input  logic              clk_in,
    input  logic              rst,
    inout  wire  [WIDTH-1:0]  PAD,
    input  logic [WIDTH-1:0]  pmux_pad_dout,
    input  logic [WIDTH-1:0]  pmux_pad_oe,
    input  logic [WIDTH-1:0]  pmux_pad_ie,
    input  logic [WIDTH-1:0]  filt_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [WIDTH-1:0]  irq_rise_en,
    input  logic [WIDTH-1:0]  irq_fall_en,
    input  logic [WIDTH-1:0]  irq_clr,
    output logic [WIDTH-1:0]  pad_pmux_din,
    output logic [WIDTH-1:0]  pad_irq,
    output logic              irq_any
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        std_pad u_pad (
            .PAD  (PAD[i]),
            .dout (pmux_pad_dout[i]),
            .oe   (pmux_pad_oe[i]),
            .ie   (pmux_pad_ie[i]),
            .din  (raw[i])
        );

        pad_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_filt (
            .clk_in   (clk_in),
            .rst      (rst),
            .raw      (raw[i]),
            .filt_en  (filt_en[i]),
            .filt_len (filt_len),
            .din      (pad_pmux_din[i]),
            .prev     (prev[i])
        );
    end

    // Enabled edges of the filtered input.
    always_comb begin
        rise = pad_pmux_din & ~prev & irq_rise_en;
        fall = ~pad_pmux_din & prev & irq_fall_en;
    end

    // Sticky flags (a new edge beats a simultaneous clear) and registered summary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pad_irq <= '0;
            irq_any <= 1'b0;
        end else begin
            pad_irq <= (pad_irq & ~irq_clr) | rise | fall;
            irq_any <= |pad_irq;
        end
    end

endmodule

// File: tb/tb_pad_port_filt.sv
// Bench for pad_port_filt (32 pins, 6-bit filter length): directed scenarios plus
// randomised traffic, all checked against a behavioural pin model.
module tb_pad_port_filt;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned FW = 6;

    logic          clk_in = 1'b0;
    logic          rst;
    wire  [W-1:0]  PAD;
    logic [W-1:0]  dout, oe, ie, fen, ren, fal, clr, ext;
    logic [FW-1:0] flen;
    logic [W-1:0]  din_o, irq_o;
    logic          any_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [W-1:0] m_hist [S];
    logic [W-1:0] m_din, m_prev, m_irq, m_en;
    logic         m_any;
    int unsigned  m_run [W];

    always #5 clk_in = ~clk_in;

    // External driver on every pin the DUT is not driving.
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign PAD[i] = oe[i] ? 1'bz : ext[i];
    end

    pad_port_filt #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .FILT_W      (FW)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .PAD           (PAD),
        .pmux_pad_dout (dout),
        .pmux_pad_oe   (oe),
        .pmux_pad_ie   (ie),
        .filt_en       (fen),
        .filt_len      (flen),
        .irq_rise_en   (ren),
        .irq_fall_en   (fal),
        .irq_clr       (clr),
        .pad_pmux_din  (din_o),
        .pad_irq       (irq_o),
        .irq_any       (any_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(S); k++) m_hist[k] = '0;
        m_din  = '0;
        m_prev = '0;
        m_irq  = '0;
        m_en   = '0;
        m_any  = 1'b0;
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
    endtask

    // One clock edge of the reference: s is the pad value seen S edges ago; a differing
    // value must be seen on filt_len+1 consecutive edges before it reaches din.
    task automatic model_edge();
        logic [W-1:0] pin, s, nd, rise, fall;
        if (rst) begin
            model_reset();
            return;
        end
        pin = (oe & dout) | (~oe & ext);
        s   = m_hist[S-1];
        nd  = m_din;
        for (int i = 0; i < int'(W); i++) begin
            if (fen[i] != m_en[i]) begin
                m_run[i] = 0;
            end else if (!fen[i]) begin
                nd[i] = s[i];
                m_run[i] = 0;
            end else if (s[i] == m_din[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] >= int'(flen)) begin
                nd[i] = s[i];
                m_run[i] = 0;
            end else begin
                m_run[i]++;
            end
        end
        rise   = m_din & ~m_prev & ren;
        fall   = ~m_din & m_prev & fal;
        m_any  = |m_irq;
        m_irq  = (m_irq & ~clr) | rise | fall;
        m_prev = m_din;
        m_din  = nd;
        m_en   = fen;
        for (int k = int'(S) - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ie & pin;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("din", din_o, m_din);
        chk("irq", irq_o, m_irq);
        chk("any", W'(any_o), W'(m_any));
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    initial begin
        int unsigned  len [W];
        logic [W-1:0] seen, mask;

        rst = 1'b1;
        dout = '0; oe = '0; ie = '1; fen = '0; ren = '0; fal = '0; clr = '0; ext = '0;
        flen = '0;
        model_reset();
        ticks(3);
        chk("reset_din", din_o, 32'h0);
        chk("reset_irq", irq_o, 32'h0);
        chk("reset_any", W'(any_o), 32'h0);
        rst = 1'b0;
        ticks(3);

        // Bypass: pin 3 rise reaches din after 3 edges, flag one later, irq_any one after that
        ren[3] = 1'b1;
        ext[3] = 1'b1;
        ticks(2);
        chk("byp_edge2", din_o, 32'h0);
        tick();
        chk("byp_edge3", din_o, 32'h8);
        chk("byp_noirq", irq_o, 32'h0);
        tick();
        chk("byp_irq", irq_o, 32'h8);
        chk("byp_any0", W'(any_o), 32'h0);
        tick();
        chk("byp_any1", W'(any_o), 32'h1);
        clr[3] = 1'b1;
        tick();
        clr = '0;
        chk("byp_clr", irq_o, 32'h0);
        tick();
        chk("byp_any_clr", W'(any_o), 32'h0);

        // Glitch filter on pin 5, filt_len=4
        fen[5] = 1'b1;
        flen   = 6'd4;
        ren[5] = 1'b1;
        ticks(3);
        ext[5] = 1'b1;
        ticks(4);
        ext[5] = 1'b0;
        ticks(10);
        chk("glitch4_din", din_o & 32'h20, 32'h0);
        chk("glitch4_irq", irq_o & 32'h20, 32'h0);
        ext[5] = 1'b1;
        ticks(6);
        chk("pulse6_edge6", din_o & 32'h20, 32'h0);
        ext[5] = 1'b0;
        tick();
        chk("pulse6_edge7", din_o & 32'h20, 32'h20);
        ticks(12);
        clr = '1;
        tick();
        clr = '0;
        ticks(2);

        // Set/clear collision on pin 7 falling edge
        fal[7] = 1'b1;
        ext[7] = 1'b1;
        ticks(5);
        chk("col_norise", irq_o, 32'h0);
        ext[7] = 1'b0;
        ticks(3);
        clr[7] = 1'b1;
        tick();
        clr = '0;
        chk("col_set_wins", irq_o, 32'h80);
        tick();
        chk("col_any", W'(any_o), 32'h1);
        clr[7] = 1'b1;
        tick();
        clr = '0;
        chk("col_lone_clr", irq_o, 32'h0);
        tick();
        chk("col_any_clr", W'(any_o), 32'h0);

        // Output pass-through and ie gating on pin 0
        oe[0] = 1'b1; dout[0] = 1'b1;
        #1 chk("oe_drive1", W'(PAD[0]), 32'h1);
        dout[0] = 1'b0;
        #1 chk("oe_drive0", W'(PAD[0]), 32'h0);
        oe[0] = 1'b0; dout[0] = 1'b1; ext[0] = 1'b0;
        #1 chk("oe_release0", W'(PAD[0]), 32'h0);
        ext[0] = 1'b1; dout[0] = 1'b0;
        #1 chk("oe_release1", W'(PAD[0]), 32'h1);
        ie[0] = 1'b0;
        ticks(4);
        chk("ie_gate", din_o & 32'h1, 32'h0);
        ie[0] = 1'b1;
        ticks(4);
        chk("ie_open", din_o & 32'h1, 32'h1);

        // Width sweep: filt_len=63, each pin gets a 63- or 64-cycle pulse
        ext = '0; fen = '1; ren = '1; fal = '0; flen = 6'd63;
        ticks(80);
        clr = '1;
        tick();
        clr = '0;
        tick();
        for (int i = 0; i < int'(W); i++) len[i] = 63 + $urandom_range(0, 1);
        len[0] = 63;
        len[1] = 64;
        mask = '0;
        for (int i = 0; i < int'(W); i++) mask[i] = (len[i] >= 64);
        seen = '0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < int'(W); i++) ext[i] = (k < int'(len[i]));
            tick();
            seen |= din_o;
        end
        chk("sweep_pass", seen, mask);
        chk("sweep_irq", irq_o, mask);
        ticks(80);
        clr = '1;
        tick();
        clr = '0;

        // Randomised traffic with a mid-run asynchronous reset
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) begin
                oe   = $urandom & $urandom;
                dout = $urandom;
                ie   = $urandom | $urandom;
                fen  = $urandom;
                ren  = $urandom;
                fal  = $urandom;
                flen = FW'($urandom_range(0, 6));
            end
            ext ^= $urandom & $urandom & $urandom;
            clr  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if (n == 400) begin
                rst = 1'b1;
                #1;
                chk("midrst_din", din_o, 32'h0);
                chk("midrst_irq", irq_o, 32'h0);
                chk("midrst_any", W'(any_o), 32'h0);
                model_reset();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
